// File: rtl/fa32_pkg.sv
// Shared constants and operand payload for the fa32bit byte-lane adder front end.
package fa32_pkg;

  localparam int unsigned LANE_W     = 8;
  localparam int unsigned NUM_LANES  = 4;
  localparam int unsigned DATA_W     = LANE_W * NUM_LANES;
  localparam int unsigned SUM_LAT    = 5;
  localparam int unsigned FIFO_DEPTH = 4;

  // Occupancy counter width for a FIFO of the given depth (must reach DEPTH itself).
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned LEVEL_W = level_w(FIFO_DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              cin;
  } op_pair_t;

  localparam int unsigned PAIR_W = $bits(op_pair_t);

endpackage

// File: rtl/op_fifo.sv
// Synchronous FIFO with registered full/empty flags and occupancy; no empty bypass.
module op_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 69
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata_c,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [LVL_W-1:0] level_nxt;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata_c = mem[rd_ptr];

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_nxt = level;
    if (do_push && !do_pop) begin
      level_nxt = level + LVL_W'(1);
    end else if (!do_push && do_pop) begin
      level_nxt = level - LVL_W'(1);
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_nxt;
      full  <= (level_nxt == LVL_W'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

endmodule

// File: rtl/fa32_operand_skew.sv
// Operand feeder for fa32bit: buffers pairs, skews byte lanes, and tracks sum coherence.
module fa32_operand_skew
  import fa32_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  parameter int unsigned TAGW  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_a,
  input  logic [31:0]               in_b,
  input  logic                      in_cin,
  input  logic [TAGW-1:0]           in_tag,
  input  logic                      issue_en,
  output logic [31:0]               a_sk,
  output logic [31:0]               b_sk,
  output logic                      cin_sk,
  output logic                      sum_valid,
  output logic [TAGW-1:0]           sum_tag,
  output logic [level_w(DEPTH)-1:0] level
);

  localparam int unsigned ENT_W = PAIR_W + TAGW;

  op_pair_t          in_pair;
  op_pair_t          head_pair;
  logic [TAGW-1:0]   head_tag;
  logic [ENT_W-1:0]  head_c;
  logic              full;
  logic              empty;
  logic              issue;

  assign in_pair  = '{a: in_a, b: in_b, cin: in_cin};
  assign in_ready = !full;
  assign issue    = issue_en && !empty;
  assign {head_tag, head_pair} = head_c;

  op_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (in_valid),
    .pop     (issue),
    .wdata   ({in_tag, in_pair}),
    .rdata_c (head_c),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // Carry-in travels with lane 0; idle cycles inject zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cin_sk <= 1'b0;
    end else begin
      cin_sk <= issue ? head_pair.cin : 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [LANE_W-1:0] a_line [k+1];
    logic [LANE_W-1:0] b_line [k+1];

    // Lane k delay line of k+1 stages, shifting every cycle; bubbles enter as zero.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j <= k; j++) begin
          a_line[j] <= '0;
          b_line[j] <= '0;
        end
      end else begin
        a_line[0] <= issue ? head_pair.a[k*LANE_W +: LANE_W] : '0;
        b_line[0] <= issue ? head_pair.b[k*LANE_W +: LANE_W] : '0;
        for (int j = 1; j <= k; j++) begin
          a_line[j] <= a_line[j-1];
          b_line[j] <= b_line[j-1];
        end
      end
    end

    assign a_sk[k*LANE_W +: LANE_W] = a_line[k];
    assign b_sk[k*LANE_W +: LANE_W] = b_line[k];
  end

  logic            tok     [SUM_LAT];
  logic [TAGW-1:0] tok_tag [SUM_LAT];

  // Token line: an issue surfaces as sum_valid exactly SUM_LAT edges later.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < int'(SUM_LAT); j++) begin
        tok[j]     <= 1'b0;
        tok_tag[j] <= '0;
      end
      sum_valid <= 1'b0;
      sum_tag   <= '0;
    end else begin
      tok[0]     <= issue;
      tok_tag[0] <= issue ? head_tag : '0;
      for (int j = 1; j < int'(SUM_LAT); j++) begin
        tok[j]     <= tok[j-1];
        tok_tag[j] <= tok_tag[j-1];
      end
      sum_valid <= tok[SUM_LAT-1];
      sum_tag   <= tok_tag[SUM_LAT-1];
    end
  end

endmodule

// File: tb/tb_fa32_operand_skew.sv
// Scoreboard bench for fa32_operand_skew with a behavioural byte-lane adder downstream.
module tb_fa32_operand_skew;

  localparam int unsigned TAGW = 4;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        in_valid = 1'b0;
  logic                        in_ready;
  logic [31:0]                 in_a = '0;
  logic [31:0]                 in_b = '0;
  logic                        in_cin = 1'b0;
  logic [TAGW-1:0]             in_tag = '0;
  logic                        issue_en = 1'b0;
  logic [31:0]                 a_sk;
  logic [31:0]                 b_sk;
  logic                        cin_sk;
  logic                        sum_valid;
  logic [TAGW-1:0]             sum_tag;
  logic [fa32_pkg::LEVEL_W-1:0] level;

  always #5 clk = ~clk;

  fa32_operand_skew #(.DEPTH(4), .TAGW(TAGW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_tag    (in_tag),
    .issue_en  (issue_en),
    .a_sk      (a_sk),
    .b_sk      (b_sk),
    .cin_sk    (cin_sk),
    .sum_valid (sum_valid),
    .sum_tag   (sum_tag),
    .level     (level)
  );

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] sum;
    logic        cout;
  } exp_t;

  exp_t exp_q[$];
  int   sv_cyc[$];
  int   cyc = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-lane ripple adder fed by the skewed lanes, with output deskew to SUM_LAT.
  logic [7:0] m_s  [4][5];
  logic       m_c  [4];
  logic       m_co [5];

  always @(posedge clk) begin
    logic [8:0] t;
    logic       ci;
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m_c[k] = 1'b0;
        for (int j = 0; j < 5; j++) m_s[k][j] = 8'h00;
      end
      for (int j = 0; j < 5; j++) m_co[j] = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++)
        for (int j = 4; j > 0; j--) m_s[k][j] = m_s[k][j-1];
      for (int j = 4; j > 0; j--) m_co[j] = m_co[j-1];
      for (int k = 3; k >= 0; k--) begin
        if (k == 0) ci = cin_sk;
        else        ci = m_c[k-1];
        t = 9'(a_sk[k*8 +: 8]) + 9'(b_sk[k*8 +: 8]) + 9'(ci);
        m_s[k][0] = t[7:0];
        m_c[k]    = t[8];
      end
      m_co[0] = m_c[3];
    end
  end

  // Monitor: every sum_valid pops one expectation and checks tag and adder result.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] ms;
    if (sum_valid === 1'b1) begin
      sv_cyc.push_back(cyc);
      ms = {m_s[3][1], m_s[2][2], m_s[1][3], m_s[0][4]};
      if (exp_q.size() == 0) begin
        check("unexpected_sum_valid", 64'(sum_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sum_tag", 64'(sum_tag), 64'(e.tag));
        check("adder_sum", 64'(ms), 64'(e.sum));
        check("adder_cout", 64'(m_co[1]), 64'(e.cout));
      end
    end
  end

  // Offer one pair for a single edge; starts and ends just after a falling edge.
  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic c,
                      input logic [3:0] tag, input logic [31:0] sum, input logic co,
                      output logic acc);
    exp_t e;
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = c; in_tag = tag;
    acc = in_ready;
    @(posedge clk);
    if (acc) begin
      e = '{tag, sum, co};
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1);
  end

  initial begin
    logic        acc;
    int          e0;
    logic [31:0] fa [5];
    logic [31:0] fb [5];
    logic        fc [5];
    logic [31:0] fs [5];
    logic        fo [5];

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_level", 64'(level), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_a_sk", 64'(a_sk), 64'd0);
    check("rst_b_sk", 64'(b_sk), 64'd0);
    check("rst_cin_sk", 64'(cin_sk), 64'd0);
    check("rst_sum_valid", 64'(sum_valid), 64'd0);
    check("rst_sum_tag", 64'(sum_tag), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single pair: lane timing and latency
    push(32'h000000FF, 32'h00000001, 1'b0, 4'd3, 32'h00000100, 1'b0, acc);
    check("t1_accept", 64'(acc), 64'd1);
    check("t1_level", 64'(level), 64'd1);
    issue_en = 1'b1;
    @(negedge clk);
    e0 = cyc;
    issue_en = 1'b0;
    check("t1_lane0_a", 64'(a_sk), 64'h000000FF);
    check("t1_lane0_b", 64'(b_sk), 64'h00000001);
    check("t1_cin", 64'(cin_sk), 64'd0);
    check("t1_level_after", 64'(level), 64'd0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check("t1_lane_a", 64'(a_sk), 64'(32'h000000FF & (32'hFF << (8*k))));
    end
    drain("t1_drain");
    check("t1_nsv", 64'(sv_cyc.size()), 64'd1);
    if (sv_cyc.size() == 1) check("t1_latency", 64'(sv_cyc[0] - e0), 64'd5);
    sv_cyc.delete();

    // Back-to-back issue
    push(32'hFFFFFFFF, 32'h00000001, 1'b0, 4'd1, 32'h00000000, 1'b1, acc);
    push(32'h12345678, 32'h11111111, 1'b1, 4'd2, 32'h2345678A, 1'b0, acc);
    issue_en = 1'b1;
    drain("t2_drain");
    issue_en = 1'b0;
    check("t2_nsv", 64'(sv_cyc.size()), 64'd2);
    if (sv_cyc.size() == 2) check("t2_consecutive", 64'(sv_cyc[1] - sv_cyc[0]), 64'd1);
    sv_cyc.delete();

    // Fill with issue held off; fifth offer must be refused
    fa = '{32'h00000001, 32'h80000000, 32'h0000FFFF, 32'h7FFFFFFF, 32'hDEADBEEF};
    fb = '{32'h00000002, 32'h80000000, 32'h00000001, 32'h00000000, 32'h00000001};
    fc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    fs = '{32'h00000003, 32'h00000000, 32'h00010000, 32'h80000000, 32'hDEADBEF0};
    fo = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      push(fa[i], fb[i], fc[i], 4'(i + 1), fs[i], fo[i], acc);
      check("t3_accept", 64'(acc), (i < 4) ? 64'd1 : 64'd0);
    end
    check("t3_level_full", 64'(level), 64'd4);
    check("t3_ready_full", 64'(in_ready), 64'd0);

    // Full with pop and push offered together: only the pop fires
    in_valid = 1'b1; in_a = 32'hCAFEF00D; in_b = 32'h0; in_cin = 1'b0; in_tag = 4'd6;
    issue_en = 1'b1;
    check("t4_ready_while_full", 64'(in_ready), 64'd0);
    check("t4_level_while_full", 64'(level), 64'd4);
    @(negedge clk);
    in_valid = 1'b0;
    check("t4_level_after_pop", 64'(level), 64'd3);
    check("t4_ready_after_pop", 64'(in_ready), 64'd1);
    drain("t4_drain");
    issue_en = 1'b0;
    check("t4_nsv", 64'(sv_cyc.size()), 64'd4);
    sv_cyc.delete();

    // Bubbles: issue, two idle cycles, issue
    push(32'hA1B2C3D4, 32'h01010101, 1'b0, 4'd7, 32'hA2B3C4D5, 1'b0, acc);
    issue_en = 1'b1;
    @(negedge clk);
    e0 = cyc;
    issue_en = 1'b0;
    in_valid = 1'b1; in_a = 32'h55667788; in_b = 32'h0F0F0F0F; in_cin = 1'b1; in_tag = 4'd8;
    check("t5_p2_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    exp_q.push_back('{4'd8, 32'h64758698, 1'b0});
    in_valid = 1'b0;
    check("t5_lanes_e1", 64'(a_sk), 64'h0000C300);
    @(negedge clk);
    check("t5_lanes_e2", 64'(a_sk), 64'h00B20000);
    issue_en = 1'b1;
    @(negedge clk);
    issue_en = 1'b0;
    check("t5_lanes_e3", 64'(a_sk), 64'hA1000088);
    check("t5_b_lanes_e3", 64'(b_sk), 64'h0100000F);
    drain("t5_drain");
    check("t5_nsv", 64'(sv_cyc.size()), 64'd2);
    if (sv_cyc.size() == 2) check("t5_gap", 64'(sv_cyc[1] - sv_cyc[0]), 64'd3);
    if (sv_cyc.size() >= 1) check("t5_first_latency", 64'(sv_cyc[0] - e0), 64'd5);
    sv_cyc.delete();

    // Reset while three pairs are in flight
    push(32'h11111111, 32'h22222222, 1'b0, 4'd9,  32'h33333333, 1'b0, acc);
    push(32'h33333333, 32'h44444444, 1'b0, 4'd10, 32'h77777777, 1'b0, acc);
    push(32'h55555555, 32'h66666666, 1'b0, 4'd11, 32'hBBBBBBBB, 1'b0, acc);
    issue_en = 1'b1;
    repeat (3) @(negedge clk);
    issue_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    sv_cyc.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_no_sum_valid", 64'(sv_cyc.size()), 64'd0);
    check("t6_level", 64'(level), 64'd0);
    check("t6_a_sk", 64'(a_sk), 64'd0);
    check("t6_in_ready", 64'(in_ready), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
